// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline-register constants: per-boundary bundle widths, control bit positions
// and the slot state encoding used by the elastic stage.
package pipe_pkg;

  localparam int IDEX_DATA_W  = 150;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 138;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 72;
  localparam int MEMWB_CTRL_W = 4;

  localparam int CTRL_BRANCH  = 0;
  localparam int CTRL_MEM_RD  = 1;
  localparam int CTRL_MEM_WR  = 2;
  localparam int CTRL_MEM2REG = 3;
  localparam int CTRL_REG_WR  = 4;
  localparam int CTRL_ALU_SRC = 5;
  localparam int CTRL_JUMP    = 6;
  localparam int CTRL_HALT    = 7;

  // Wide enough for 2*DEPTH entries at the largest legal DEPTH of 4.
  localparam int OCC_W = 4;

  localparam logic [1:0] SLOT_EMPTY = 2'd0;
  localparam logic [1:0] SLOT_HALF  = 2'd1;
  localparam logic [1:0] SLOT_FULL  = 2'd2;

  function automatic logic [1:0] slot_state(input logic main_valid, input logic skid_valid);
    if (skid_valid)      return SLOT_FULL;
    else if (main_valid) return SLOT_HALF;
    else                 return SLOT_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle of one elastic pipeline register: upstream side, downstream side,
// flush and occupancy. The stage itself takes the slave view.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = pipe_pkg::EXMEM_DATA_W,
  parameter int CTRL_W = pipe_pkg::EXMEM_CTRL_W
) ();

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [CTRL_W-1:0]          in_ctrl;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [CTRL_W-1:0]          out_ctrl;
  logic [pipe_pkg::OCC_W-1:0] occupancy;

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

endinterface

// File: rtl/pipe_stage_elastic_skid_slot.sv
// One elastic slot: main register plus skid register, so the ready it offers upstream
// is a flop (!FULL) and never a combinational function of the downstream ready.
module skid_slot import pipe_pkg::*; #(
  parameter int DATA_W           = EXMEM_DATA_W,
  parameter int CTRL_W           = EXMEM_CTRL_W,
  parameter bit CLEAR_DATA_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        held
);

  logic              main_valid, skid_valid, ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic       take_in, take_out;
  logic       load_main_in, load_main_skid, load_skid;
  logic [1:0] state;

  assign state    = slot_state(main_valid, skid_valid);
  assign take_in  = up_valid & ready_q;
  assign take_out = main_valid & dn_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SLOT_EMPTY: load_main_in = take_in;
      SLOT_HALF: begin
        load_main_in = take_in & take_out;
        load_skid    = take_in & ~take_out;
      end
      SLOT_FULL:  load_main_skid = take_out;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else begin
      if (load_main_in) begin
        main_valid <= 1'b1;
        main_ctrl  <= up_ctrl;
      end else if (load_main_skid) begin
        main_ctrl  <= skid_ctrl;
      end else if (take_out) begin
        main_valid <= 1'b0;
      end
      if (load_skid) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= up_ctrl;
        ready_q    <= 1'b0;
      end else if (load_main_skid) begin
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end
  end

  // NOTE: the data registers are reset too, so out_data is a known zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      if (CLEAR_DATA_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main_in)        main_data <= up_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= up_data;
    end
  end

  assign up_ready = ready_q;
  assign dn_valid = main_valid;
  assign dn_data  = main_data;
  assign dn_ctrl  = main_ctrl;
  assign held     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH chained skid slots, an occupancy adder across all slots,
// and control masked to NOP whenever the output holds a bubble.
module pipe_stage_elastic import pipe_pkg::*; #(
  parameter int DATA_W           = EXMEM_DATA_W,
  parameter int CTRL_W           = EXMEM_CTRL_W,
  parameter int DEPTH            = 1,
  parameter bit CLEAR_DATA_FLUSH = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  pipe_stage_elastic_if.slave bus
);

  logic              stage_valid [DEPTH+1];
  logic              stage_ready [DEPTH+1];
  logic [DATA_W-1:0] stage_data  [DEPTH+1];
  logic [CTRL_W-1:0] stage_ctrl  [DEPTH+1];
  logic [1:0]        held        [DEPTH];
  logic [OCC_W-1:0]  occ;

  assign stage_valid[0]     = bus.in_valid;
  assign stage_data[0]      = bus.in_data;
  assign stage_ctrl[0]      = bus.in_ctrl;
  assign stage_ready[DEPTH] = bus.out_ready;
  assign bus.in_ready       = stage_ready[0];

  for (genvar i = 0; i < DEPTH; i++) begin : gen_slot
    skid_slot #(
      .DATA_W           (DATA_W),
      .CTRL_W           (CTRL_W),
      .CLEAR_DATA_FLUSH (CLEAR_DATA_FLUSH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .up_valid (stage_valid[i]),
      .up_ready (stage_ready[i]),
      .up_data  (stage_data[i]),
      .up_ctrl  (stage_ctrl[i]),
      .dn_valid (stage_valid[i+1]),
      .dn_ready (stage_ready[i+1]),
      .dn_data  (stage_data[i+1]),
      .dn_ctrl  (stage_ctrl[i+1]),
      .held     (held[i])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(held[i]);
  end

  assign bus.occupancy = occ;
  assign bus.out_valid = stage_valid[DEPTH];
  assign bus.out_data  = stage_data[DEPTH];
  assign bus.out_ctrl  = stage_valid[DEPTH] ? stage_ctrl[DEPTH] : '0;

endmodule
